// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if
//   Groups the byte handshake and serial-line signals of the UART transmitter.
//   master : the client that requests bytes (drives tx_start/tx_data)
//   slave  : the transmitter (drives tx, tx_busy, tx_done)
//   Signals:
//     tx_start  request to send tx_data (sampled only while the transmitter idles)
//     tx_data   byte to send, captured on the accepting edge
//     tx        serial line, idles high
//     tx_busy   high from the accepting edge until the frame completes
//     tx_done   one-cycle pulse at frame completion
interface uart_tx_serializer_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (output tx_start, output tx_data, input tx, input tx_busy, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART transmitter: accepts one byte per handshake and sends a framed
//   character on tx -- start bit, 8 data bits LSB first, optional parity bit,
//   one stop bit. Each bit lasts CLKS_PER_BIT clock cycles.
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> 11-bit frame with a parity bit (PARITY_ODD selects the sense)
//     undefined -> 10-bit frame, no parity logic, PARITY_ODD unused
//   Ports:
//     clk     system clock, rising edge
//     preset  synchronous active-high reset (abandons any frame in flight)
//     bus     uart_tx_serializer_if.slave (tx_start, tx_data, tx, tx_busy, tx_done)
//   tx, tx_busy and tx_done all come straight from flops.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 5208,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 preset,
  uart_tx_serializer_if.slave  bus
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  // Even parity makes the total count of ones even; odd inverts it.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
`endif

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]       idx_r, idx_nxt_s;
  logic [7:0]       byte_r, byte_nxt_s;
  logic             tx_r, tx_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic             bit_end_s;

  // Last cycle of the current bit period.
  assign bit_end_s = (cnt_r == CNT_LAST);

  // Next-state and next-output logic; tx is computed one cycle ahead so it can be registered.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    byte_nxt_s  = byte_r;
    tx_nxt_s    = tx_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        idx_nxt_s = 3'd0;
        if (bus.tx_start) begin
          byte_nxt_s  = bus.tx_data;
          state_nxt_s = ST_START;
          tx_nxt_s    = 1'b0;
          busy_nxt_s  = 1'b1;
        end else begin
          tx_nxt_s   = 1'b1;
          busy_nxt_s = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_DATA;
          tx_nxt_s    = byte_r[0];
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_nxt_s = CNT_ZERO;
          if (idx_r == 3'd7) begin
            idx_nxt_s = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_nxt_s = ST_PARITY;
            tx_nxt_s    = parity_bit(byte_r, PARITY_ODD);
`else
            state_nxt_s = ST_STOP;
            tx_nxt_s    = 1'b1;
`endif
          end else begin
            idx_nxt_s = idx_r + 3'd1;
            tx_nxt_s  = byte_r[idx_r + 3'd1];
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_STOP;
          tx_nxt_s    = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end_s) begin
          // Frame ends: busy drops and done pulses on the same edge.
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_IDLE;
          tx_nxt_s    = 1'b1;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
        idx_nxt_s   = 3'd0;
        tx_nxt_s    = 1'b1;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; preset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (preset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
      byte_r  <= 8'h00;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      byte_r  <= byte_nxt_s;
      tx_r    <= tx_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign bus.tx      = tx_r;
  assign bus.tx_busy = busy_r;
  assign bus.tx_done = done_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (even and odd parity sense)
// share the same stimulus; a negedge monitor decodes every frame and checks
// it against bytes queued when the request was driven.
module tb_uart_tx_serializer;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int F = 10;
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       preset;
  logic       tx_start;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  bit mon_en    = 1'b0;
  bit mon_abort = 1'b0;

  uart_tx_serializer_if if_e ();
  uart_tx_serializer_if if_o ();

  assign if_e.tx_start = tx_start;
  assign if_e.tx_data  = tx_data;
  assign if_o.tx_start = tx_start;
  assign if_o.tx_data  = tx_data;

  logic [1:0] tx_v, busy_v, done_v;
  assign tx_v   = {if_o.tx, if_e.tx};
  assign busy_v = {if_o.tx_busy, if_e.tx_busy};
  assign done_v = {if_o.tx_done, if_e.tx_done};

  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .preset(preset), .bus(if_e)
  );
  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .preset(preset), .bus(if_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference frame, bit k at position k; positions past the frame read as 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] b, input bit odd);
    logic [10:0] f;
    f = 11'h7FF;
    f[0] = 1'b0;
    f[8:1] = b;
    if (PAR_EN) f[9] = (^b) ^ odd;
    return f;
  endfunction

  // Number of cycles tx spends low during one frame of byte b.
  function automatic int exp_low(input logic [7:0] b, input bit odd);
    int n;
    n = C;
    for (int k = 0; k < 8; k++) if (b[k] == 1'b0) n += C;
    if (PAR_EN && (((^b) ^ odd) == 1'b0)) n += C;
    return n;
  endfunction

  // Frame monitor and scoreboard.
  initial begin
    int          ncyc[2];
    logic [10:0] bits[2];
    bit          prev_busy[2];
    logic [7:0]  eb;
    bit          have;
    logic [10:0] ef;
    for (int i = 0; i < 2; i++) begin ncyc[i] = 0; bits[i] = 11'h7FF; prev_busy[i] = 1'b0; end
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (busy_v[i] === 1'b1 && done_v[i] === 1'b1) begin
            errors++;
            $display("FAIL busy_done_exclusive dut%0d: busy=%b done=%b, required not both high", i, busy_v[i], done_v[i]);
          end
          if (busy_v[i] === 1'b1) begin
            if (!prev_busy[i]) begin ncyc[i] = 0; bits[i] = 11'h7FF; end
            if ((ncyc[i] % C) == (C / 2) && (ncyc[i] / C) < F) bits[i][ncyc[i] / C] = tx_v[i];
            ncyc[i]++;
            prev_busy[i] = 1'b1;
          end else if (prev_busy[i]) begin
            prev_busy[i] = 1'b0;
            have = 1'b0;
            eb = 8'h00;
            if (i == 0) begin
              if (exp_q0.size() > 0) begin have = 1'b1; eb = exp_q0.pop_front(); end
            end else begin
              if (exp_q1.size() > 0) begin have = 1'b1; eb = exp_q1.pop_front(); end
            end
            if (!mon_abort) begin
              checks++;
              if (!have) begin
                errors++;
                $display("FAIL unexpected_frame dut%0d: frame 0x%03h sent, required no frame", i, bits[i]);
              end else begin
                ef = exp_frame(eb, i == 1);
                checks++;
                if (bits[i] !== ef) begin
                  errors++;
                  $display("FAIL frame_bits dut%0d byte 0x%02h: got 0x%03h, required 0x%03h", i, eb, bits[i], ef);
                end
                checks++;
                if (ncyc[i] != F * C) begin
                  errors++;
                  $display("FAIL busy_length dut%0d: got %0d cycles, required %0d", i, ncyc[i], F * C);
                end
                checks++;
                if (done_v[i] !== 1'b1) begin
                  errors++;
                  $display("FAIL done_at_end dut%0d: tx_done=%b, required 1", i, done_v[i]);
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request one byte from idle; expects acceptance on the next edge.
  task automatic send_byte(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    exp_q0.push_back(b);
    exp_q1.push_back(b);
    tick();
    tx_start = 1'b0;
    checks++;
    if (busy_v !== 2'b11 || tx_v !== 2'b00) begin
      errors++;
      $display("FAIL accept_latency byte 0x%02h: busy=%b tx=%b, required busy=11 tx=00", b, busy_v, tx_v);
    end
  endtask

  // Advance until tx_done, counting low tx cycles and busy cycles on the way.
  task automatic run_frame(output int low0, output int low1, output int busy_n);
    bit got;
    low0 = 0; low1 = 0; busy_n = 0; got = 1'b0;
    for (int c = 0; c < 2 * F * C + 8; c++) begin
      if (done_v[0] === 1'b1) begin got = 1'b1; break; end
      if (tx_v[0] === 1'b0) low0++;
      if (tx_v[1] === 1'b0) low1++;
      if (busy_v[0] === 1'b1) busy_n++;
      tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL frame_timeout: tx_done not seen within %0d cycles", 2 * F * C + 8);
    end else begin
      checks++;
      if (done_v !== 2'b11 || busy_v !== 2'b00 || tx_v !== 2'b11) begin
        errors++;
        $display("FAIL done_cycle: done=%b busy=%b tx=%b, required done=11 busy=00 tx=11", done_v, busy_v, tx_v);
      end
    end
  endtask

  task automatic test_reset();
    preset   = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'hE7;
    repeat (3) tick();
    checks++;
    if (tx_v !== 2'b11 || busy_v !== 2'b00 || done_v !== 2'b00) begin
      errors++;
      $display("FAIL reset_values: tx=%b busy=%b done=%b, required 11/00/00", tx_v, busy_v, done_v);
    end
    preset   = 1'b0;
    tx_start = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy_v !== 2'b00 || tx_v !== 2'b11) begin
      errors++;
      $display("FAIL reset_drops_request: busy=%b tx=%b, required 00/11", busy_v, tx_v);
    end
    mon_en = 1'b1;
  endtask

  // Sends b and checks busy length, tx-low time and the single done pulse.
  task automatic test_frame(input logic [7:0] b, input string name);
    int l0, l1, bn;
    send_byte(b);
    run_frame(l0, l1, bn);
    checks++;
    if (bn != F * C) begin
      errors++;
      $display("FAIL %s_busy: got %0d cycles, required %0d", name, bn, F * C);
    end
    checks++;
    if (l0 != exp_low(b, 1'b0) || l1 != exp_low(b, 1'b1)) begin
      errors++;
      $display("FAIL %s_low_time: got even=%0d odd=%0d, required even=%0d odd=%0d", name, l0, l1, exp_low(b, 1'b0), exp_low(b, 1'b1));
    end
    tick();
    checks++;
    if (done_v !== 2'b00 || tx_v !== 2'b11) begin
      errors++;
      $display("FAIL %s_done_pulse: done=%b tx=%b after pulse, required 00/11", name, done_v, tx_v);
    end
    tick();
  endtask

  task automatic test_busy_reject();
    int l0, l1, bn, extra_busy, extra_done;
    send_byte(8'h81);
    repeat (15) tick();
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    run_frame(l0, l1, bn);
    extra_busy = 0;
    extra_done = 0;
    for (int c = 0; c < 2 * F * C; c++) begin
      tick();
      if (busy_v !== 2'b00) extra_busy++;
      if (done_v !== 2'b00) extra_done++;
    end
    checks++;
    if (extra_busy != 0 || extra_done != 0) begin
      errors++;
      $display("FAIL busy_reject: extra busy=%0d done=%0d cycles, required 0/0", extra_busy, extra_done);
    end
  endtask

  task automatic test_back_to_back();
    int l0, l1, bn1, bn2;
    tx_data  = 8'h12;
    tx_start = 1'b1;
    exp_q0.push_back(8'h12);
    exp_q1.push_back(8'h12);
    tick();
    checks++;
    if (busy_v !== 2'b11 || tx_v !== 2'b00) begin
      errors++;
      $display("FAIL b2b_first_accept: busy=%b tx=%b, required 11/00", busy_v, tx_v);
    end
    tx_data = 8'h34;
    run_frame(l0, l1, bn1);
    exp_q0.push_back(8'h34);
    exp_q1.push_back(8'h34);
    tick();
    tx_start = 1'b0;
    checks++;
    if (busy_v !== 2'b11 || tx_v !== 2'b00 || done_v !== 2'b00) begin
      errors++;
      $display("FAIL b2b_second_start: busy=%b tx=%b done=%b, required 11/00/00", busy_v, tx_v, done_v);
    end
    run_frame(l0, l1, bn2);
    checks++;
    if (bn1 + bn2 != 2 * F * C) begin
      errors++;
      $display("FAIL b2b_busy_total: got %0d cycles, required %0d", bn1 + bn2, 2 * F * C);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    send_byte(8'h5A);
    repeat (4 * C + 1) tick();
    mon_abort = 1'b1;
    preset    = 1'b1;
    tick();
    preset = 1'b0;
    checks++;
    if (tx_v !== 2'b11 || busy_v !== 2'b00 || done_v !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_frame: tx=%b busy=%b done=%b, required 11/00/00", tx_v, busy_v, done_v);
    end
    bad = 0;
    for (int c = 0; c < 2 * F * C; c++) begin
      tick();
      if (tx_v !== 2'b11 || busy_v !== 2'b00 || done_v !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d active cycles after reset, required 0", bad);
    end
    mon_abort = 1'b0;
  endtask

  initial begin
    preset   = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    test_frame(8'hA5, "basic");
    test_frame(8'hFF, "odd_parity");
    test_frame(8'h00, "all_zero");
    test_busy_reject();
    test_back_to_back();
    test_reset_mid_frame();
    test_frame(8'h6B, "after_reset");
    repeat (3) tick();
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d bytes never sent, required 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmitter that pairs with the receive-side shift register. It accepts one byte per handshake and sends it on `tx` as a framed asynchronous character: start bit, 8 data bits LSB first, optional parity bit, and one stop bit. Bit timing comes from an internal baud counter clocked by the 50 MHz system clock. The framing matches the receiver's 11-bit frame when parity is compiled in.

## Interface

- `CLKS_PER_BIT`, default 5208: clock cycles per bit (50 MHz / 9600 baud); minimum 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; used only when parity is compiled in.

- `clk`  input  1  50 MHz system clock; all logic on rising edge.
- `preset`  input  1  synchronous, active-high reset.
- `tx_start`  input  1  request to send `tx_data`; sampled only while idle.
- `tx_data`  input  8  byte to send; captured on the accepting edge.
- `tx`  output  1  serial line; idles high.
- `tx_busy`  output  1  high from the accepting edge until the frame completes.
- `tx_done`  output  1  one-cycle pulse at frame completion.

## Operation

- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, FSM=IDLE, baud counter=0, bit index=0.
- States: IDLE → START → DATA → PARITY (macro only) → STOP → IDLE.
- **IDLE:**
  - `tx`=1.
  - If `tx_start`=1: latch `tx_data` into the internal byte register, clear the baud counter, go to START.
  - `tx_busy` and `tx`=0 take effect on the same edge.
- **START:** `tx`=0 for `CLKS_PER_BIT` cycles.
- **DATA:**
  - `tx`=byte[bit_idx] for bit_idx 0..7, each held `CLKS_PER_BIT` cycles.
  - bit_idx increments on each baud-counter wrap.
  - After bit 7, go to PARITY or STOP.
- **PARITY:** `tx` = (^byte) XOR `PARITY_ODD`, held `CLKS_PER_BIT` cycles.
- **STOP:** `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE with `tx_busy`=0 and `tx_done`=1.
- Baud counter:
  - Width is $clog2(`CLKS_PER_BIT`).
  - Counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on the bit transition.
  - Does not advance in IDLE.
- Handshake and boundary rules:
  - `tx_start` while `tx_busy`=1 is ignored; no queuing.
  - `tx_data` changes during a frame have no effect.
  - `tx_done` and `tx_busy` are mutually exclusive.
  - `tx_start` asserted in the `tx_done` cycle is accepted (FSM is IDLE). This gives back-to-back frames with no idle bit-time.
  - `preset` mid-frame: the frame is abandoned, `tx`=1 on the next edge, and no `tx_done` pulse is generated.
  - `preset` together with `tx_start`: reset wins and the request is dropped.

## Timing

- Let the accepting edge be E0, and let F be 11 with parity, 10 without.
- After E0: `tx`=0, `tx_busy`=1.
- Bit k (k=0 is the start bit) is driven from edge E0+k·`CLKS_PER_BIT` for `CLKS_PER_BIT` cycles.
- At edge E0+F·`CLKS_PER_BIT`: `tx_busy`=0, `tx_done`=1.
- At the next edge: `tx_done`=0.
- Frame length is exactly F·`CLKS_PER_BIT` cycles with `tx_busy`=1.
- Latency from `tx_start` to the start-bit falling edge on `tx` is 1 cycle.
- `tx` is driven directly from a flop, with no combinational path from inputs.

## Configuration

- Macro: `UART_TX_PARITY_EN`.
- Defined: PARITY state included; 11-bit frame (start, 8 data, parity, stop); `PARITY_ODD` selects the sense.
- Undefined: PARITY state and parity logic omitted; DATA goes directly to STOP; 10-bit frame; `PARITY_ODD` ignored.

## Test plan

- **Basic frame:** with macro defined, `CLKS_PER_BIT`=4, `PARITY_ODD`=0, send 0xA5.
  - Expect `tx` sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles.
  - Expect `tx_busy` high for 44 cycles, then one `tx_done` pulse.
- **Odd parity:** `PARITY_ODD`=1, send 0xFF.
  - Expect parity bit=1 and stop=1.
  - Expect `tx` low exactly 4 cycles (start bit only).
- **Busy rejection:** pulse `tx_start` with 0x3C mid-frame of 0x81.
  - Expect only 0x81 transmitted.
  - Expect exactly one `tx_done` pulse and no second frame.
- **Back-to-back:** hold `tx_start`=1 with 0x12 then 0x34, and assert `tx_start` in the `tx_done` cycle.
  - Expect the second start bit to begin the next cycle.
  - Expect no idle high bit between frames and a total of 88 busy cycles minus the one `tx_done` cycle.
- **Reset mid-frame:** assert `preset` during DATA bit 3.
  - Expect `tx`=1, `tx_busy`=0, `tx_done`=0 on the next edge, and no further transitions.
- **Parity compiled out:** without macro, `CLKS_PER_BIT`=4, send 0x00.
  - Expect `tx` low 36 cycles, then stop high for 4 cycles.
  - Expect `tx_busy` high for 40 cycles.
